spram_arbiter: RTL and testbench
================================

// Module: spram_arbiter
// PURPOSE
//   Two-port round-robin arbiter and sequencer in front of the 128KB single-port SPRAM (32k x 32).
//   Shares the memory between two masters, typically CPU instruction fetch (port 0) and CPU data/DMA (port 1).
//   Each master uses a valid/ready handshake. The arbiter drives registered sel/we/addr/wdat to the memory.
//   It returns the SPRAM's one-cycle-latency read data to the winning master.
// PARAMETERS
//   ADDR_W      17  byte-address width of the memory (128KB)
//   FIXED_PRIO  0   0: round-robin between ports; 1: port 0 always wins a tie
// PORTS
//   clk        in   1      single clock; all logic on posedge
//   resetn     in   1      asynchronous, active-low reset
//   rN_valid   in   1      (N=0,1) request; held until rN_ready
//   rN_addr    in   ADDR_W byte address; bits [1:0] ignored
//   rN_wdat    in   32     write data
//   rN_we      in   4      byte write strobes; 4'b0000 = read
//   rN_ready   out  1      one-cycle completion pulse
//   rN_rdat    out  32     read data, valid only while rN_ready=1
//   mem_sel    out  1      memory chip select (registered)
//   mem_we     out  4      memory byte write enables (registered)
//   mem_addr   out  ADDR_W memory byte address (registered)
//   mem_wdat   out  32     memory write data (registered)
//   mem_rdat   in   32     memory read data, valid the cycle after mem_sel
//   busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//   Reset (async assert, sync release):
//     state=IDLE; mem_sel=0, mem_we=0, mem_addr=0, mem_wdat=0; r0_ready=r1_ready=0; busy=0; rr_ptr=0.
//   FSM: IDLE -> ISSUE -> RESP -> IDLE. An access takes 3 cycles. At most one access is in flight.
//   IDLE
//     - No valid: stay in IDLE; mem_* outputs keep their values and mem_sel stays 0.
//     - One valid: that port wins.
//     - Both valid: the port selected by rr_ptr wins (rr_ptr=0 -> port 0). With FIXED_PRIO=1, port 0 wins.
//     - On a win: register the winner's addr/wdat/we into mem_*, set mem_sel=1, latch gnt=winner, go to ISSUE.
//   ISSUE
//     - mem_sel=1 for exactly this cycle; the memory samples at the end of the cycle.
//     - Next state RESP; mem_sel->0, mem_we->0.
//   RESP
//     - r<gnt>_ready=1 and r<gnt>_rdat=mem_rdat (combinational pass-through).
//     - The other port's ready=0 and its rdat=0.
//     - A write still pulses ready; rdat is don't-care.
//     - Round-robin: rr_ptr <= ~gnt. Next state IDLE.
//   Latency: valid seen at cycle t -> mem_sel at t+1 -> ready at t+2.
//     A master that drops valid after ready is re-arbitrated no earlier than t+3.
//   Fairness: under constant contention, grants alternate 0,1,0,1 (round-robin mode).
//   Bounds:
//     - A master that holds valid across its own ready starts a new access; it is not a duplicate of the same transfer.
//     - A master that drops valid after grant is a protocol violation. The access still completes and the ready pulse is still emitted.
//     - Requests are never reordered, merged or pipelined.
//     - Address wrap: only bits [ADDR_W-1:0] are forwarded. No range error exists.
//     - Reset mid-access: the access is abandoned, no ready pulse is produced, mem_sel drops immediately.
//       A write in ISSUE at reset may or may not land.
// STRUCTURE
//   Shared package soc_pkg:
//     - localparams SPRAM_ADDR_W=17 and SPRAM_DATA_W=32.
//     - FSM encodings ST_IDLE=2'd0, ST_ISSUE=2'd1, ST_RESP=2'd2.
//   Unused encoding 2'd3 returns to IDLE with all outputs at reset values.
//   One sub-module, rr_pick2: combinational 2-way pick from (valid[1:0], ptr, fixed) -> gnt, any.
//   The FSM and registers stay in spram_arbiter.
// TESTING
//   1. Reset: hold resetn=0 with both valid=1 -> mem_sel=0, both ready=0, busy=0; after release, first grant goes to port 0.
//   2. Single read: preload word 0x0100=0xDEADBEEF; r0 reads addr 0x00400 at t.
//      -> mem_sel=1, mem_addr=0x00400 at t+1; r0_ready=1, r0_rdat=0xDEADBEEF at t+2.
//   3. Byte write: r1 writes we=4'b0010, wdat=0x0000AB00 to 0x1FFFC, then reads it back.
//      -> only byte 1 changes; at 0x1FFFC, byte 1 reads back 0xAB and bytes 0, 2 and 3 keep their old values.
//   4. Contention: both ports hold valid for 8 accesses -> grants alternate 0,1,0,1; each port gets 4; no ready overlap.
//      With FIXED_PRIO=1 -> port 0 gets all grants while its valid is held.
//   5. Reset mid-access: assert resetn=0 during ISSUE -> mem_sel=0 asynchronously, no ready pulse, FSM in IDLE after release.
//   6. Bank boundary: r0 writes 0x11111111 to 0x0FFFC and 0x22222222 to 0x10000 -> both read back intact.

Source files
------------

// File: rtl/soc_pkg.sv
// ---------------------------------------------------------------------------
// soc_pkg
//   Shared definitions for the SoC memory subsystem.
//   SPRAM_ADDR_W / SPRAM_DATA_W : geometry of the 128KB single-port SPRAM
//                                 (byte address width, data word width).
//   arb_state_e                 : sequencer states of the SPRAM arbiter.
// ---------------------------------------------------------------------------
package soc_pkg;

  localparam int SPRAM_ADDR_W = 17;
  localparam int SPRAM_DATA_W = 32;

  // Encoding 2'd3 is unused; the arbiter recovers from it to ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
//   Combinational two-way winner selection.
//   Ports:
//     valid[1:0] in  : request lines of port 0 / port 1
//     ptr        in  : round-robin pointer, port favoured on a tie
//     fixed      in  : 1 = port 0 always wins a tie, ptr ignored
//     gnt        out : index of the winning port (0 when nothing requests)
//     any        out : at least one request present
// ---------------------------------------------------------------------------
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  input  logic       fixed,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |valid;
    gnt = 1'b0;
    if (valid == 2'b11) begin
      // Tie: the pointer decides unless fixed priority is in force.
      gnt = fixed ? 1'b0 : ptr;
    end else if (valid == 2'b10) begin
      gnt = 1'b1;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// ---------------------------------------------------------------------------
// spram_arbiter
//   Two-port arbiter and sequencer in front of the 32k x 32 single-port
//   SPRAM. Each access runs IDLE -> ISSUE -> RESP -> IDLE, one access at a
//   time. Memory-side controls are registered; read data is passed straight
//   from the SPRAM to the winning master during RESP.
//   Ports:
//     clk, resetn          : clock, asynchronous active-low reset
//     rN_valid/addr/wdat/we: request from master N (we == 0 means read)
//     rN_ready             : one-cycle completion pulse to master N
//     rN_rdat              : read data, non-zero only while rN_ready
//     mem_sel/we/addr/wdat : registered SPRAM controls
//     mem_rdat             : SPRAM read data, valid the cycle after mem_sel
//     busy                 : an access is in ISSUE or RESP
//   Parameters:
//     ADDR_W     : byte address width forwarded to the memory
//     FIXED_PRIO : 0 round-robin on a tie, 1 port 0 always wins a tie
// ---------------------------------------------------------------------------
module spram_arbiter
  import soc_pkg::*;
#(
  parameter int ADDR_W     = SPRAM_ADDR_W,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                    clk,
  input  logic                    resetn,

  input  logic                    r0_valid,
  input  logic [ADDR_W-1:0]       r0_addr,
  input  logic [SPRAM_DATA_W-1:0] r0_wdat,
  input  logic [3:0]              r0_we,
  output logic                    r0_ready,
  output logic [SPRAM_DATA_W-1:0] r0_rdat,

  input  logic                    r1_valid,
  input  logic [ADDR_W-1:0]       r1_addr,
  input  logic [SPRAM_DATA_W-1:0] r1_wdat,
  input  logic [3:0]              r1_we,
  output logic                    r1_ready,
  output logic [SPRAM_DATA_W-1:0] r1_rdat,

  output logic                    mem_sel,
  output logic [3:0]              mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [SPRAM_DATA_W-1:0] mem_wdat,
  input  logic [SPRAM_DATA_W-1:0] mem_rdat,

  output logic                    busy
);

  arb_state_e              state_q, state_d;
  logic                    gnt_q, gnt_d;
  logic                    rr_ptr_q, rr_ptr_d;
  logic                    mem_sel_q, mem_sel_d;
  logic [3:0]              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [SPRAM_DATA_W-1:0] mem_wdat_q, mem_wdat_d;

  logic pick_gnt;
  logic pick_any;

  rr_pick2 u_pick (
    .valid ({r1_valid, r0_valid}),
    .ptr   (rr_ptr_q),
    .fixed (FIXED_PRIO),
    .gnt   (pick_gnt),
    .any   (pick_any)
  );

  // Next-state and memory-control logic. mem_sel defaults low so it is only
  // ever high for the single ISSUE cycle; address and write data hold their
  // last value between accesses.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    mem_sel_d  = 1'b0;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdat_d = mem_wdat_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d    = ST_ISSUE;
          gnt_d      = pick_gnt;
          mem_sel_d  = 1'b1;
          mem_we_d   = pick_gnt ? r1_we   : r0_we;
          mem_addr_d = pick_gnt ? r1_addr : r0_addr;
          mem_wdat_d = pick_gnt ? r1_wdat : r0_wdat;
        end
      end

      ST_ISSUE: begin
        state_d  = ST_RESP;
        mem_we_d = 4'b0000;
      end

      ST_RESP: begin
        // The port just served loses the next tie.
        rr_ptr_d = ~gnt_q;
        state_d  = ST_IDLE;
      end

      default: begin
        state_d    = ST_IDLE;
        gnt_d      = 1'b0;
        rr_ptr_d   = 1'b0;
        mem_we_d   = 4'b0000;
        mem_addr_d = '0;
        mem_wdat_d = '0;
      end
    endcase
  end

  // State and memory-control registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      rr_ptr_q   <= 1'b0;
      mem_sel_q  <= 1'b0;
      mem_we_q   <= 4'b0000;
      mem_addr_q <= '0;
      mem_wdat_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      mem_sel_q  <= mem_sel_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdat_q <= mem_wdat_d;
    end
  end

  // Response side: ready and read data are decoded from the state so the
  // SPRAM output reaches the master in the same cycle it appears.
  always_comb begin
    r0_ready = (state_q == ST_RESP) && !gnt_q;
    r1_ready = (state_q == ST_RESP) &&  gnt_q;
    r0_rdat  = r0_ready ? mem_rdat : '0;
    r1_rdat  = r1_ready ? mem_rdat : '0;
    busy     = (state_q == ST_ISSUE) || (state_q == ST_RESP);
  end

  assign mem_sel  = mem_sel_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wdat = mem_wdat_q;

endmodule

// File: tb/tb_spram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spram_arbiter
//   Self-checking bench for spram_arbiter: directed scenarios with literal
//   expectations, then randomized two-master traffic. A transaction-level
//   model predicts every output on every cycle from request timing.
// ---------------------------------------------------------------------------
module tb_spram_arbiter;

  localparam int AW = 17;

  logic            clk;
  logic            resetn;
  logic [1:0]      vld;
  logic [AW-1:0]   addr_in [2];
  logic [31:0]     wdat_in [2];
  logic [3:0]      we_in   [2];
  logic            r0_ready, r1_ready;
  logic [31:0]     r0_rdat, r1_rdat;
  logic            mem_sel;
  logic [3:0]      mem_we;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdat;
  logic [31:0]     mem_rdat;
  logic            busy;

  // Second instance with fixed priority, driven separately.
  logic [1:0]      fp_vld;
  logic [AW-1:0]   fp_addr0, fp_addr1;
  logic [31:0]     fp_wdat0;
  logic            fp_r0_ready, fp_r1_ready;
  logic [31:0]     fp_r0_rdat, fp_r1_rdat;
  logic            fp_mem_sel;
  logic [3:0]      fp_mem_we;
  logic [AW-1:0]   fp_mem_addr;
  logic [31:0]     fp_mem_wdat;
  logic [31:0]     fp_mem_rdat;
  logic            fp_busy;

  int checks = 0;
  int errors = 0;

  spram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b0)) u_dut (
    .clk(clk), .resetn(resetn),
    .r0_valid(vld[0]), .r0_addr(addr_in[0]), .r0_wdat(wdat_in[0]), .r0_we(we_in[0]),
    .r0_ready(r0_ready), .r0_rdat(r0_rdat),
    .r1_valid(vld[1]), .r1_addr(addr_in[1]), .r1_wdat(wdat_in[1]), .r1_we(we_in[1]),
    .r1_ready(r1_ready), .r1_rdat(r1_rdat),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdat(mem_wdat),
    .mem_rdat(mem_rdat), .busy(busy)
  );

  spram_arbiter #(.ADDR_W(AW), .FIXED_PRIO(1'b1)) u_dut_fp (
    .clk(clk), .resetn(resetn),
    .r0_valid(fp_vld[0]), .r0_addr(fp_addr0), .r0_wdat(fp_wdat0), .r0_we(4'b0000),
    .r0_ready(fp_r0_ready), .r0_rdat(fp_r0_rdat),
    .r1_valid(fp_vld[1]), .r1_addr(fp_addr1), .r1_wdat(32'h0), .r1_we(4'b0000),
    .r1_ready(fp_r1_ready), .r1_rdat(fp_r1_rdat),
    .mem_sel(fp_mem_sel), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdat(fp_mem_wdat),
    .mem_rdat(fp_mem_rdat), .busy(fp_busy)
  );

  assign fp_mem_rdat = 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Power-up contents of every SPRAM word, with two pinned words.
  function automatic logic [31:0] init_word(input int idx);
    if (idx == 32'h0100) return 32'hDEADBEEF;
    if (idx == 32'h7FFF) return 32'h11223344;
    return (32'(idx) * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got 0x%08h, required 0x%08h", name, $time, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // SPRAM behavioural memory: one-cycle read latency, byte write strobes.
  // -------------------------------------------------------------------------
  logic [31:0] mem [int];

  initial begin
    mem_rdat = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_sel) begin
        int          idx;
        logic [31:0] w;
        idx = int'(mem_addr[AW-1:2]);
        w   = mem.exists(idx) ? mem[idx] : init_word(idx);
        mem_rdat <= w;
        if (mem_we != 4'b0000) mem[idx] = merge_bytes(w, mem_wdat, mem_we);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Reference model and per-cycle comparison. The model reasons in whole
  // transactions: a request seen while the arbiter is free at cycle c is
  // issued to memory at c+1, completes at c+2, and the arbiter is free again
  // from c+3. It keeps its own copy of memory contents.
  // -------------------------------------------------------------------------
  logic [31:0] shadow [int];
  int          cycle   = 0;
  int          m_issue = -100;
  int          m_resp  = -100;
  int          m_next  = 0;
  int          m_gnt   = 0;
  int          m_ptr   = 0;
  logic [AW-1:0] m_addr = '0;
  logic [3:0]  m_we    = 4'b0;
  logic [31:0] m_wdat  = 32'h0;
  logic        m_read  = 1'b0;
  logic [31:0] m_rdat  = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (!resetn) begin
        m_issue = -100;
        m_resp  = -100;
        m_next  = cycle + 1;
        m_ptr   = 0;
        m_addr  = '0;
        m_we    = 4'b0;
        m_wdat  = 32'h0;
        checkOutput("rst_mem_sel",  32'(mem_sel),  32'h0);
        checkOutput("rst_mem_we",   32'(mem_we),   32'h0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
        checkOutput("rst_mem_wdat", mem_wdat,      32'h0);
        checkOutput("rst_r0_ready", 32'(r0_ready), 32'h0);
        checkOutput("rst_r1_ready", 32'(r1_ready), 32'h0);
        checkOutput("rst_busy",     32'(busy),     32'h0);
      end else begin
        checkOutput("mem_sel",  32'(mem_sel),  32'(cycle == m_issue));
        checkOutput("mem_we",   32'(mem_we),   (cycle == m_issue) ? 32'(m_we) : 32'h0);
        checkOutput("mem_addr", 32'(mem_addr), 32'(m_addr));
        checkOutput("mem_wdat", mem_wdat,      m_wdat);
        checkOutput("busy",     32'(busy),     32'((cycle == m_issue) || (cycle == m_resp)));
        checkOutput("r0_ready", 32'(r0_ready), 32'((cycle == m_resp) && (m_gnt == 0)));
        checkOutput("r1_ready", 32'(r1_ready), 32'((cycle == m_resp) && (m_gnt == 1)));
        if (cycle == m_resp) begin
          if (m_read) checkOutput("rdat", (m_gnt == 1) ? r1_rdat : r0_rdat, m_rdat);
          checkOutput("other_rdat", (m_gnt == 1) ? r0_rdat : r1_rdat, 32'h0);
        end
        if (cycle >= m_next && vld != 2'b00) begin
          int idx;
          if (vld == 2'b11) m_gnt = m_ptr;
          else              m_gnt = vld[1] ? 1 : 0;
          m_ptr   = 1 - m_gnt;
          m_issue = cycle + 1;
          m_resp  = cycle + 2;
          m_next  = cycle + 3;
          m_addr  = addr_in[m_gnt];
          m_we    = we_in[m_gnt];
          m_wdat  = wdat_in[m_gnt];
          m_read  = (m_we == 4'b0000);
          idx     = int'(m_addr[AW-1:2]);
          m_rdat  = shadow.exists(idx) ? shadow[idx] : init_word(idx);
          if (!m_read) shadow[idx] = merge_bytes(m_rdat, m_wdat, m_we);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers. Inputs change 1 time unit after a rising edge.
  // -------------------------------------------------------------------------
  task automatic applyStimulus(input int p, input logic [AW-1:0] a,
                               input logic [3:0] w, input logic [31:0] d);
    vld[p]     = 1'b1;
    addr_in[p] = a;
    we_in[p]   = w;
    wdat_in[p] = d;
  endtask

  task automatic waitReady(input int p, output logic [31:0] rd);
    int n = 0;
    bit found = 0;
    rd = 32'h0;
    while (!found && n < 12) begin
      @(posedge clk); #1;
      n++;
      if ((p == 1) ? r1_ready : r0_ready) begin
        found = 1;
        rd = (p == 1) ? r1_rdat : r0_rdat;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL ready_timeout port %0d: got no ready, required ready within 12 cycles", p);
    end
  endtask

  task automatic doAccess(input int p, input logic [AW-1:0] a, input logic [3:0] w,
                          input logic [31:0] d, output logic [31:0] rd);
    applyStimulus(p, a, w, d);
    waitReady(p, rd);
    @(posedge clk); #1;
    vld[p] = 1'b0;
  endtask

  task automatic newRandomReq(input int p);
    logic [31:0] r;
    logic [3:0]  w;
    r = $urandom;
    if ($urandom_range(0, 3) != 0) r = r & 32'h0000_00FC;
    w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom);
    applyStimulus(p, AW'(r) & 17'h1FFFC, w, $urandom);
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios followed by randomized traffic.
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] rd;
    int          n, cnt0, cnt1, fp_n, fp_cnt0, guard;
    bit          saw [2];

    resetn = 1'b0;
    vld    = 2'b00;
    fp_vld = 2'b00;
    for (int p = 0; p < 2; p++) begin
      addr_in[p] = '0;
      wdat_in[p] = 32'h0;
      we_in[p]   = 4'b0;
    end
    fp_addr0 = 17'h00040;
    fp_addr1 = 17'h00080;
    fp_wdat0 = 32'hCAFE0001;

    // Reset held with both masters requesting.
    applyStimulus(0, 17'h00000, 4'b0000, 32'h0);
    applyStimulus(1, 17'h00004, 4'b0000, 32'h0);
    repeat (3) begin
      @(posedge clk); #1;
      checkOutput("reset_sel",    32'(mem_sel),  32'h0);
      checkOutput("reset_ready0", 32'(r0_ready), 32'h0);
      checkOutput("reset_ready1", 32'(r1_ready), 32'h0);
      checkOutput("reset_busy",   32'(busy),     32'h0);
    end
    resetn = 1'b1;
    waitReady(0, rd);
    checkOutput("first_grant_r0", 32'(r0_ready), 32'h1);
    checkOutput("first_grant_r1", 32'(r1_ready), 32'h0);
    @(posedge clk); #1;
    vld = 2'b00;

    // Single read: sel/addr one cycle after the request, data one cycle later.
    applyStimulus(0, 17'h00400, 4'b0000, 32'h0);
    @(posedge clk); #1;
    checkOutput("read_issue_sel",  32'(mem_sel),  32'h1);
    checkOutput("read_issue_addr", 32'(mem_addr), 32'h00400);
    checkOutput("read_issue_rdy",  32'(r0_ready), 32'h0);
    @(posedge clk); #1;
    checkOutput("read_ready", 32'(r0_ready), 32'h1);
    checkOutput("read_rdat",  r0_rdat,       32'hDEADBEEF);
    @(posedge clk); #1;
    vld[0] = 1'b0;

    // Byte write at the top word, then read back.
    doAccess(1, 17'h1FFFC, 4'b0010, 32'h0000AB00, rd);
    doAccess(1, 17'h1FFFC, 4'b0000, 32'h0, rd);
    checkOutput("byte_write", rd, 32'h1122AB44);

    // Sustained contention on both instances.
    applyStimulus(0, 17'h00040, 4'b0000, 32'h0);
    applyStimulus(1, 17'h00080, 4'b0000, 32'h0);
    fp_vld = 2'b11;
    n = 0; cnt0 = 0; cnt1 = 0; fp_n = 0; fp_cnt0 = 0; guard = 0;
    while ((n < 8 || fp_n < 8) && guard < 60) begin
      @(posedge clk); #1;
      guard++;
      checkOutput("ready_overlap", 32'(r0_ready & r1_ready), 32'h0);
      if (n < 8 && (r0_ready || r1_ready)) begin
        checkOutput("rr_order", 32'(r1_ready), 32'(n % 2));
        if (r0_ready) cnt0++; else cnt1++;
        n++;
      end
      if (fp_n < 8 && (fp_r0_ready || fp_r1_ready)) begin
        checkOutput("fp_grant_r1",  32'(fp_r1_ready), 32'h0);
        checkOutput("fp_busy",      32'(fp_busy),     32'h1);
        checkOutput("fp_mem_sel",   32'(fp_mem_sel),  32'h0);
        checkOutput("fp_mem_we",    32'(fp_mem_we),   32'h0);
        checkOutput("fp_mem_addr",  32'(fp_mem_addr), 32'(fp_addr0));
        checkOutput("fp_mem_wdat",  fp_mem_wdat,      fp_wdat0);
        checkOutput("fp_rdat",      fp_r0_rdat | fp_r1_rdat, 32'h0);
        if (fp_r0_ready) fp_cnt0++;
        fp_n++;
      end
      if (n >= 8) vld = 2'b00;
      if (fp_n >= 8) fp_vld = 2'b00;
    end
    vld = 2'b00;
    fp_vld = 2'b00;
    checkOutput("rr_count0", 32'(cnt0),    32'd4);
    checkOutput("rr_count1", 32'(cnt1),    32'd4);
    checkOutput("fp_count0", 32'(fp_cnt0), 32'd8);
    repeat (3) @(posedge clk);
    #1;

    // Bank boundary writes and read-back.
    doAccess(0, 17'h0FFFC, 4'b1111, 32'h11111111, rd);
    doAccess(0, 17'h10000, 4'b1111, 32'h22222222, rd);
    doAccess(0, 17'h0FFFC, 4'b0000, 32'h0, rd);
    checkOutput("bank_lo", rd, 32'h11111111);
    doAccess(0, 17'h10000, 4'b0000, 32'h0, rd);
    checkOutput("bank_hi", rd, 32'h22222222);

    // Reset during ISSUE.
    applyStimulus(0, 17'h00200, 4'b0000, 32'h0);
    @(posedge clk); #1;
    checkOutput("midrst_issue", 32'(mem_sel), 32'h1);
    resetn = 1'b0;
    vld[0] = 1'b0;
    #1;
    checkOutput("midrst_sel_async", 32'(mem_sel), 32'h0);
    checkOutput("midrst_busy",      32'(busy),    32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("midrst_no_ready", 32'(r0_ready), 32'h0);
    end
    resetn = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("midrst_idle_busy",  32'(busy),     32'h0);
      checkOutput("midrst_idle_ready", 32'(r0_ready), 32'h0);
    end

    // Randomized traffic from both masters; the model checks every cycle.
    saw[0] = 0;
    saw[1] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (vld[p] && saw[p]) begin
          if ($urandom_range(0, 1) == 0) newRandomReq(p);
          else vld[p] = 1'b0;
        end else if (!vld[p] && $urandom_range(0, 3) == 0) begin
          newRandomReq(p);
        end
        saw[p] = (p == 1) ? r1_ready : r0_ready;
      end
    end
    // Let any outstanding accesses drain before stopping.
    guard = 0;
    while (vld != 2'b00 && guard < 40) begin
      @(posedge clk); #1;
      guard++;
      if (r0_ready) vld[0] = 1'b0;
      if (r1_ready) vld[1] = 1'b0;
    end
    vld = 2'b00;
    repeat (5) @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
